// File: rtl/ssi_pkg.sv
// Shared constants for the seven-segment driver: active-low segment patterns,
// FSM encoding and overflow threshold helpers.
package ssi_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    ENCODE  = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  function automatic logic [63:0] pow16(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r << 4;
    return r;
  endfunction

endpackage

// File: rtl/ssi_digit_decode.sv
// Combinational nibble to seven-segment decoder with hex enable, blank/dash
// overrides and selectable output polarity.
module ssi_digit_decode
  import ssi_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       hex_en,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] segments
);

  logic [6:0] pat;

  always_comb begin
    pat = SEG_BLANK;
    if (dash) begin
      pat = SEG_DASH;
    end else if (!blank) begin
      case (nibble)
        4'h0: pat = SEG_0;
        4'h1: pat = SEG_1;
        4'h2: pat = SEG_2;
        4'h3: pat = SEG_3;
        4'h4: pat = SEG_4;
        4'h5: pat = SEG_5;
        4'h6: pat = SEG_6;
        4'h7: pat = SEG_7;
        4'h8: pat = SEG_8;
        4'h9: pat = SEG_9;
        4'hA: pat = hex_en ? SEG_A : SEG_BLANK;
        4'hB: pat = hex_en ? SEG_B : SEG_BLANK;
        4'hC: pat = hex_en ? SEG_C : SEG_BLANK;
        4'hD: pat = hex_en ? SEG_D : SEG_BLANK;
        4'hE: pat = hex_en ? SEG_E : SEG_BLANK;
        4'hF: pat = hex_en ? SEG_F : SEG_BLANK;
        default: pat = SEG_BLANK;
      endcase
    end
  end

  assign segments = (ACTIVE_LOW != 0) ? pat : ~pat;

endmodule

// File: rtl/ssi_display_driver.sv
// Multi-digit seven-segment driver: binary value in over valid/ready, decimal
// (double-dabble) or hex digits out with leading-zero blanking and overflow dashes.
module ssi_display_driver
  import ssi_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int VALUE_W    = 14,
  parameter int HEX_MODE   = 0,
  parameter int LZ_BLANK   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [VALUE_W-1:0]    i_value,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_blank,
  output logic [7*DIGITS-1:0]   o_segments,
  output logic                  o_overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam int NIB_W = (VALUE_W < BCD_W) ? VALUE_W : BCD_W;
  localparam logic [6:0] POL = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
  localparam logic [7*DIGITS-1:0] ALL_BLANK = {DIGITS{SEG_BLANK ^ POL}};

  function automatic logic [7*DIGITS-1:0] reset_pattern();
    logic [7*DIGITS-1:0] r;
    for (int d = 0; d < DIGITS; d++)
      r[7*d +: 7] = (d == 0 || LZ_BLANK == 0) ? (SEG_0 ^ POL) : (SEG_BLANK ^ POL);
    return r;
  endfunction

  localparam logic [7*DIGITS-1:0] RST_SEG = reset_pattern();

  state_t               state;
  logic [VALUE_W-1:0]   shift_q;
  logic [BCD_W-1:0]     bcd_q;
  logic                 ovf_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [7*DIGITS-1:0]  held_q;
  logic [7*DIGITS-1:0]  seg_next;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     hex_nib;
  logic [DIGITS-1:0]    dig_blank;
  logic                 hex_ovf;
  logic                 accept;

  assign accept  = i_valid && o_ready;
  assign hex_ovf = 64'(i_value) >= pow16(DIGITS);

  always_comb begin
    hex_nib = '0;
    for (int i = 0; i < NIB_W; i++) hex_nib[i] = i_value[i];
  end

  // Double-dabble adjust: any BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < DIGITS; d++)
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
  end

  always_comb begin
    logic nz_above;
    nz_above  = 1'b0;
    dig_blank = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nz_above     = nz_above | (bcd_q[4*d +: 4] != 4'd0);
      dig_blank[d] = (LZ_BLANK != 0) && (d != 0) && !nz_above;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    ssi_digit_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
      .nibble   (bcd_q[4*g +: 4]),
      .hex_en   (HEX_MODE != 0),
      .blank    (dig_blank[g]),
      .dash     (ovf_q),
      .segments (seg_next[7*g +: 7])
    );
  end

  // Conversion datapath: loaded on accept, stepped while converting.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      shift_q <= i_value;
      cnt_q   <= '0;
      if (HEX_MODE != 0) begin
        bcd_q <= hex_nib;
        ovf_q <= hex_ovf;
      end else begin
        bcd_q <= '0;
        ovf_q <= 1'b0;
      end
    end else if (state == CONVERT) begin
      bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[VALUE_W-1]};
      ovf_q   <= ovf_q | bcd_adj[BCD_W-1];
      shift_q <= shift_q << 1;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Control FSM and registered display outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      o_ready    <= 1'b1;
      o_overflow <= 1'b0;
      held_q     <= RST_SEG;
      o_segments <= RST_SEG;
    end else begin
      o_segments <= i_blank ? ALL_BLANK : ((state == ENCODE) ? seg_next : held_q);
      case (state)
        IDLE: begin
          if (accept) begin
            o_ready <= 1'b0;
            state   <= (HEX_MODE != 0) ? ENCODE : CONVERT;
          end
        end
        CONVERT: begin
          if (cnt_q == CNT_W'(VALUE_W - 1)) state <= ENCODE;
        end
        ENCODE: begin
          held_q     <= seg_next;
          o_overflow <= ovf_q;
          o_ready    <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ssi_display_driver.md
Name: ssi_display_driver

Overview:
Parametrised multi-digit seven-segment driver. Accepts a binary value over a valid/ready handshake. Converts it to BCD with a sequential shift-add-3 (double-dabble) engine, or to hex nibbles in hex mode. Registers DIGITS segment patterns with leading-zero blanking, overflow indication and global blanking. Sits between the metronome datapath (BPM/count values) and the board's seven-segment pins.

Parameters:
DIGITS, 4, number of displayed digits (1..8)
VALUE_W, 14, width of the binary input (1..32)
HEX_MODE, 0, 0 = decimal via BCD conversion, 1 = hexadecimal digits 0-F
LZ_BLANK, 1, 1 = blank leading zeros (digit 0 always shown)
ACTIVE_LOW, 1, 1 = segment lit when bit is 0, 0 = inverted polarity

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  synchronous, active-low reset
i_value  input  VALUE_W  binary value to display
i_valid  input  1  i_value is valid
o_ready  output  1  driver can accept a value
i_blank  input  1  force all segments off
o_segments  output  7*DIGITS  digit d at bits [7d+6:7d]; digit 0 is least significant; bit order g..a (bit6 = g, bit0 = a)
o_overflow  output  1  last accepted value does not fit in DIGITS digits

Behaviour:
- Reset: one clock and one synchronous, active-low reset (i_reset_n sampled on rising i_clk). On a reset edge:
  - state = IDLE, o_ready = 1, o_overflow = 0
  - digit 0 shows "0"; other digits blank if LZ_BLANK = 1, else "0"
  - internal held value cleared
- Reset mid-conversion aborts the conversion; no partial result ever reaches o_segments.
- Handshake: accept on an edge where i_valid && o_ready. The value is captured and o_ready drops on that edge. While o_ready = 0, i_valid is ignored (no queueing).
- FSM:
  - IDLE: on accept, go to CONVERT (HEX_MODE = 0) or ENCODE (HEX_MODE = 1).
  - CONVERT: exactly VALUE_W cycles of shift-add-3 on a 4*DIGITS-bit BCD register, plus the captured carry-out/overflow detection. Then go to ENCODE.
  - ENCODE: one cycle. Register o_segments and o_overflow, set o_ready = 1, return to IDLE.
- Latency: o_segments updates VALUE_W+1 edges after the accept edge in decimal mode, 1 edge in hex mode. A new value may be accepted on the edge after ENCODE.
- Overflow:
  - Condition: value >= 10^DIGITS (decimal) or >= 16^DIGITS (hex; possible only if VALUE_W > 4*DIGITS).
  - Response: all digits show dash (only g lit, 7'b0111111 active-low), o_overflow = 1. LZ_BLANK does not apply.
- Digit encoding (active-low): 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000.
- Hex letters: A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
- Blank pattern: 1111111.
- ACTIVE_LOW = 0 inverts every pattern. Non-decimal nibbles in decimal mode cannot occur; the decoder default is blank.
- Leading-zero blanking: every digit above the most significant nonzero digit is blank. A value of 0 shows a single "0" in digit 0.
- i_blank:
  - Registered: o_segments reads blank from the edge after i_blank is sampled high.
  - Does not stall or corrupt a conversion. The held result is restored on the edge after i_blank is sampled low.
  - If ENCODE completes while i_blank is high, the new result is held and shown after release.
  - o_overflow is unaffected by i_blank.

Decomposition:
- Package ssi_pkg:
  - segment pattern constants SEG_0..SEG_F, SEG_DASH, SEG_BLANK (active-low)
  - FSM state encoding (IDLE, CONVERT, ENCODE)
  - function pow10/pow16 for overflow thresholds
- Sub-module ssi_digit_decode: combinational 4-bit nibble -> 7-bit pattern with hex enable and polarity. Instantiated DIGITS times by a generate loop.
- The BCD engine stays inline.

Test Plan:
1. Default params, reset released, i_value = 1234 with i_valid for 1 cycle -> o_ready low for 15 edges. Then o_segments digits 3..0 = 1111001, 0100100, 0110000, 0011001; o_overflow = 0.
2. i_value = 7 -> digits 3..1 = 1111111, digit 0 = 1111000. i_value = 0 -> only digit 0 = 1000000. With LZ_BLANK = 0, i_value = 7 -> 1000000 ×3, then 1111000.
3. i_value = 10000 -> all four digits 0111111, o_overflow = 1. Then i_value = 9999 -> four × 0010000, o_overflow = 0.
4. Accept 42, then pulse i_valid with 99 during CONVERT -> 99 ignored, display shows 42. Then assert i_reset_n = 0 for one edge mid-conversion of 555 -> reset display, o_ready = 1, no 555 pattern ever appears.
5. i_blank high while showing 1234 -> all 1111111 next edge. Accept 5678 during blank -> stays blank. Release -> 5678 shown on the next edge.
6. HEX_MODE = 1, DIGITS = 4, VALUE_W = 16, i_value = 16'h02AF -> one edge later: digit3 blank, digits 2..0 = 0100100, 0001000, 0001110. i_value = 16'hFFFF -> four × 0001110.
